// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-granular arbiter sharing one uart_tx byte channel among NUM_REQ requesters.
// One ARB cycle per grant; the owner holds the channel until its last byte or an idle-watchdog release.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             uart_data,
  output logic                   uart_valid,
  input  logic                   uart_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam bit WD_EN = (IDLE_TIMEOUT > 0);
  localparam logic [CW-1:0] WD_LIMIT = (IDLE_TIMEOUT > 0) ? CW'(IDLE_TIMEOUT - 1) : '0;

  typedef enum logic {ARB = 1'b0, OWN = 1'b1} state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [PW-1:0]       r_owner;
  logic [PW-1:0]       r_rr_ptr;
  logic [CW-1:0]       r_idle_cnt;
  logic                r_timeout;

  logic                w_pick_vld;
  logic [PW-1:0]       w_pick_idx;
  logic [NUM_REQ-1:0]  w_pick_oh;
  logic                w_own;
  logic                w_own_vld;
  logic                w_own_last;
  logic                w_accept;
  logic                w_idle_inc;
  logic                w_expire;
  logic [PW-1:0]       w_next_ptr;

  // Descending scan so the requester closest to r_rr_ptr overwrites the others.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = PW'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_pick_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
  assign w_own      = (r_state == OWN);
  assign w_own_vld  = req_valid[r_owner];
  assign w_own_last = req_last[r_owner];
  assign w_accept   = w_own && w_own_vld && uart_ready;
  assign w_idle_inc = WD_EN && w_own && uart_ready && !w_own_vld;
  assign w_expire   = w_idle_inc && (r_idle_cnt == WD_LIMIT);
  assign w_next_ptr = (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + PW'(1);

  assign uart_data  = w_own ? req_data[{r_owner, 3'b000} +: 8] : 8'h00;
  assign uart_valid = w_accept;
  assign req_ready  = (w_own && uart_ready) ? r_grant : '0;
  assign grant      = r_grant;
  assign busy       = w_own;
  assign timeout    = r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ARB: begin
          if (w_pick_vld) begin
            r_state    <= OWN;
            r_grant    <= w_pick_oh;
            r_owner    <= w_pick_idx;
            r_idle_cnt <= '0;
          end
        end
        OWN: begin
          if (w_accept) begin
            r_idle_cnt <= '0;
            if (w_own_last) begin
              r_state  <= ARB;
              r_grant  <= '0;
              r_rr_ptr <= w_next_ptr;
            end
          end else if (w_expire) begin
            r_state    <= ARB;
            r_grant    <= '0;
            r_rr_ptr   <= w_next_ptr;
            r_idle_cnt <= '0;
            r_timeout  <= 1'b1;
          end else if (w_idle_inc) begin
            r_idle_cnt <= r_idle_cnt + CW'(1);
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized frames scored against a frame-level model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic [7:0]  uart_data;
  logic        uart_valid, uart_ready, busy, timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .IDLE_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .uart_data(uart_data), .uart_valid(uart_valid), .uart_ready(uart_ready),
    .grant(grant), .busy(busy), .timeout(timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q_dat[4][$];
  bit         q_last[4][$];
  int         drop[4];
  bit         force_bp, rand_busy, rand_drop;
  int         busy_cnt, busy_len, cyc, n_to;

  int         log_req[$];
  logic [7:0] log_dat[$];
  bit         log_last[$];
  int         log_cyc[$];
  int         exp_req[$];
  logic [7:0] exp_dat[$];
  bit         exp_last[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic void drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (q_dat[i].size() > 0) && (drop[i] == 0);
      req_data[8*i +: 8] = (q_dat[i].size() > 0) ? q_dat[i][0] : 8'h00;
      req_last[i]        = (q_last[i].size() > 0) ? q_last[i][0] : 1'b0;
    end
    uart_ready = (busy_cnt == 0) && !force_bp;
  endfunction

  function automatic void clear_log();
    log_req.delete(); log_dat.delete(); log_last.delete(); log_cyc.delete();
  endfunction

  // One clock: sample at negedge, retire accepted bytes and advance the uart model after the edge.
  task automatic tick();
    logic [3:0] s_rdy, s_vld, s_gnt;
    logic       s_uv, s_ur, s_busy;
    logic [7:0] s_ud;
    @(negedge clk);
    s_rdy = req_ready; s_vld = req_valid; s_gnt = grant;
    s_uv = uart_valid; s_ur = uart_ready; s_busy = busy; s_ud = uart_data;
    chk("grant_onehot0", 32'($onehot0(s_gnt)), 1);
    chk("busy_vs_grant", s_busy, s_gnt != 4'h0);
    chk("valid_without_ready", s_uv & ~s_ur, 0);
    chk("ready_non_owner", s_rdy & ~s_gnt, 0);
    for (int i = 0; i < 4; i++)
      if (s_uv && s_gnt[i]) chk("uart_data_mux", s_ud, q_dat[i][0]);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (s_vld[i] && s_rdy[i]) begin
        log_req.push_back(i);
        log_dat.push_back(q_dat[i][0]);
        log_last.push_back(q_last[i][0]);
        log_cyc.push_back(cyc);
        void'(q_dat[i].pop_front());
        void'(q_last[i].pop_front());
      end
    end
    if (s_uv && s_ur) busy_cnt = rand_busy ? int'($urandom_range(1, 6)) : busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    for (int i = 0; i < 4; i++) begin
      if (drop[i] > 0) drop[i]--;
      else if (rand_drop && grant[i] && $urandom_range(0, 7) == 0) drop[i] = int'($urandom_range(1, 3));
    end
    if (timeout === 1'b1) n_to++;
    drive();
  endtask

  // Frame-level reference: every queued requester is continuously valid, so the
  // byte stream is whole frames taken in round-robin order from the start pointer.
  task automatic build_expect(input int start);
    logic [7:0] d[4][$];
    bit         l[4][$];
    int         p, g;
    bit         found, lst;
    for (int i = 0; i < 4; i++) begin d[i] = q_dat[i]; l[i] = q_last[i]; end
    exp_req.delete(); exp_dat.delete(); exp_last.delete();
    p = start;
    do begin
      found = 1'b0;
      g = 0;
      for (int k = 3; k >= 0; k--)
        if (d[(p + k) % 4].size() > 0) begin found = 1'b1; g = (p + k) % 4; end
      if (found) begin
        lst = 1'b0;
        while (!lst && d[g].size() > 0) begin
          exp_req.push_back(g);
          exp_dat.push_back(d[g].pop_front());
          lst = l[g].pop_front();
          exp_last.push_back(lst);
        end
        p = (g + 1) % 4;
      end
    end while (found);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q_dat[0].size() + q_dat[1].size() + q_dat[2].size() + q_dat[3].size()) > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_within_budget", n < budget, 1);
  endtask

  task automatic compare_log();
    chk("accept_count", log_req.size(), exp_req.size());
    for (int k = 0; k < log_req.size() && k < exp_req.size(); k++) begin
      chk("accept_owner", log_req[k], exp_req[k]);
      chk("accept_data", log_dat[k], exp_dat[k]);
      chk("accept_last", log_last[k], exp_last[k]);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit l);
    q_dat[r].push_back(d);
    q_last[r].push_back(l);
  endtask

  initial begin
    int n, idle, bad_rdy;
    bit seen;
    logic [3:0] trace[$];

    rst = 1'b1; force_bp = 0; rand_busy = 0; rand_drop = 0;
    busy_cnt = 0; busy_len = 2; cyc = 0; n_to = 0;
    for (int i = 0; i < 4; i++) drop[i] = 0;
    drive();
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_uart_valid", uart_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_uart_data", uart_data, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_rr_ptr", dut.r_rr_ptr, 0);
    chk("rst_idle_cnt", dut.r_idle_cnt, 0);
    rst = 1'b0;

    // Single frame at 25 MHz / 9600 baud.
    busy_len = 2604;
    push(1, 8'h48, 0); push(1, 8'h69, 1);
    clear_log();
    drive();
    chk("single_arb_grant", grant, 4'b0000);
    tick();
    chk("single_grant", grant, 4'b0010);
    chk("single_busy", busy, 1);
    n = 0;
    while (log_req.size() < 2 && n < 8000) begin tick(); n++; end
    chk("single_accepts", log_req.size(), 2);
    if (log_req.size() == 2) begin
      chk("single_byte0", log_dat[0], 8'h48);
      chk("single_byte1", log_dat[1], 8'h69);
      chk("single_spacing", (log_cyc[1] - log_cyc[0]) >= 2604, 1);
    end
    chk("single_release", grant, 0);
    chk("single_rr_ptr", dut.r_rr_ptr, 2);

    // Round-robin from reset.
    busy_len = 2; busy_cnt = 0;
    push(0, 8'hA0, 1); push(2, 8'hA2, 1); push(3, 8'hA3, 1);
    rst = 1'b1; drive();
    tick(); tick();
    chk("rr_grant_in_reset", grant, 0);
    rst = 1'b0;
    build_expect(0);
    clear_log();
    trace.delete();
    trace.push_back(grant);
    for (int k = 0; k < 30; k++) begin tick(); trace.push_back(grant); end
    chk("rr_first_grant", trace[1], 4'b0001);
    for (int k = 1; k < trace.size(); k++)
      if (trace[k] != 4'h0 && trace[k] != trace[k-1]) chk("rr_arb_gap", trace[k-1], 0);
    compare_log();

    // Frame lock: requester 1 waits for requester 0's whole frame.
    push(0, 8'hB0, 0); push(0, 8'hB1, 0); push(0, 8'hB2, 1); push(1, 8'hC1, 1);
    build_expect(0);
    clear_log();
    drive();
    seen = 0; bad_rdy = 0; n = 0;
    while (!seen && n < 500) begin
      tick(); n++;
      foreach (log_req[k]) if (log_req[k] == 0 && log_last[k]) seen = 1;
      if (!seen && req_ready[1]) bad_rdy++;
    end
    chk("lock_no_ready_r1", bad_rdy, 0);
    tick();
    chk("lock_then_r1", grant, 4'b0010);
    drain(500);
    compare_log();

    // Watchdog release.
    n_to = 0;
    push(2, 8'hD2, 0);
    clear_log();
    drive();
    n = 0;
    while (log_req.size() < 1 && n < 100) begin tick(); n++; end
    chk("wd_first_accept", log_req.size(), 1);
    idle = 0; n = 0;
    while (timeout !== 1'b1 && n < 200) begin
      if (uart_ready && !req_valid[2]) idle++;
      tick(); n++;
    end
    chk("wd_pulse_seen", timeout, 1);
    chk("wd_idle_cycles", idle, 16);
    chk("wd_grant", grant, 0);
    chk("wd_busy", busy, 0);
    chk("wd_rr_ptr", dut.r_rr_ptr, 3);
    tick();
    chk("wd_pulse_width", timeout, 0);
    chk("wd_pulse_count", n_to, 1);

    // Back-pressure with the owner holding valid data.
    force_bp = 1;
    push(3, 8'hE0, 0); push(3, 8'hE1, 0); push(3, 8'hE2, 1);
    drive();
    tick();
    chk("bp_grant", grant, 4'b1000);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_uart_valid", uart_valid, 0);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_idle_cnt", dut.r_idle_cnt, 0);
    end

    // Reset in the middle of requester 3's frame.
    force_bp = 0;
    clear_log();
    drive();
    n = 0;
    while (log_req.size() < 1 && n < 100) begin tick(); n++; end
    chk("mid_first_accept", log_req.size(), 1);
    rst = 1'b1; drive();
    tick();
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_uart_valid", uart_valid, 0);
    rst = 1'b0;
    chk("mid_rst_rr_ptr", dut.r_rr_ptr, 0);
    push(1, 8'hF1, 1);
    build_expect(0);
    clear_log();
    drive();
    tick();
    chk("mid_restart_grant", grant, 4'b0010);
    drain(500);
    compare_log();

    // Randomized frames with random uart timing and short mid-frame valid drops.
    for (int r = 0; r < 4; r++) begin
      rst = 1'b1; drive();
      tick();
      rst = 1'b0;
      rand_busy = 1; rand_drop = 1; n_to = 0;
      for (int i = 0; i < 4; i++) begin
        int nf;
        nf = int'($urandom_range(0, 3));
        for (int f = 0; f < nf; f++) begin
          int nb;
          nb = int'($urandom_range(1, 4));
          for (int b = 0; b < nb; b++) push(i, 8'($urandom), b == nb - 1);
        end
      end
      build_expect(0);
      clear_log();
      drive();
      drain(3000);
      compare_log();
      chk("rand_no_timeout", n_to, 0);
      rand_busy = 0; rand_drop = 0;
      for (int i = 0; i < 4; i++) drop[i] = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte channel among NUM_REQ requesters, for example a debug console, a status reporter and a fault logger.
- Grants are round-robin at frame granularity. A frame is a run of bytes ending with a byte flagged last. The owner keeps the channel until its last byte is accepted or its idle watchdog expires.
- Sits directly in front of uart_tx: uart_data/uart_valid drive tx_data/tx_valid, and uart_ready is driven by tx_ready.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDLE_TIMEOUT, 1024, cycles an owner may stall while uart_ready=1 before forced release. 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of the frame.
- req_ready  out  NUM_REQ  byte accepted from requester i when req_valid[i] && req_ready[i].
- uart_data  out  8  byte to uart_tx.
- uart_valid  out  1  to uart_tx tx_valid.
- uart_ready  in  1  from uart_tx tx_ready (high only while the transmitter is idle).
- grant  out  NUM_REQ  one-hot current owner; all zero when unowned.
- busy  out  1  high while a frame owner exists.
- timeout  out  1  one-cycle pulse on a watchdog release.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=ARB, grant=0, rr_ptr=0, idle_cnt=0, timeout=0.
  - Combinational outputs follow from this: uart_valid=0, req_ready=0, busy=0, uart_data=0.
  - Reset mid-frame drops ownership immediately. The in-flight uart_tx byte is not this block's concern.
- State ARB:
  - If any req_valid is set, pick the first i, scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Register grant=onehot(i) and go to OWN next cycle, so arbitration latency is 1 cycle.
  - Only req_valid is sampled in ARB. No byte is accepted in ARB.
- State OWN, with owner g:
  - uart_data = req_data[g] (combinational mux).
  - uart_valid = req_valid[g] && uart_ready.
  - req_ready[g] = uart_ready. All other req_ready bits are 0.
  - A byte is accepted when req_valid[g] && uart_ready. Exactly one byte per accept cycle.
  - uart_ready falls on the cycle after an accept, so a second byte cannot be accepted until uart_tx returns to idle.
  - Accept with req_last[g]=1: next cycle state=ARB, grant=0, rr_ptr=(g+1) mod NUM_REQ. There is at least one ARB cycle between frames.
  - Accept with req_last=0: stay in OWN and clear idle_cnt.
- Watchdog (IDLE_TIMEOUT>0, in OWN):
  - idle_cnt increments each cycle where uart_ready=1 and req_valid[g]=0.
  - idle_cnt clears on an accept. It holds while uart_ready=0.
  - When idle_cnt==IDLE_TIMEOUT-1 and the increment condition holds: next cycle state=ARB, grant=0, rr_ptr=(g+1) mod NUM_REQ, timeout=1 for exactly one cycle, idle_cnt=0.
  - Counter width is clog2(IDLE_TIMEOUT+1).
- Simultaneous events:
  - Accept and watchdog expiry cannot coincide, because the increment requires req_valid[g]=0.
  - Non-owner req_valid is ignored during OWN; those requesters see req_ready=0 and must hold.
  - A requester dropping req_valid mid-frame is legal and only feeds the watchdog.
- Invariants:
  - grant is one-hot or zero.
  - busy = (state==OWN).
  - uart_valid never asserts while uart_ready=0.
  - rr_ptr changes only on release.

Test Plan:
- Single frame: req 1 sends 0x48, 0x69 (last on 0x69) with the uart_tx model at 25 MHz / 9600 baud. Required: grant=0010 one cycle after req_valid, two accepts 2604+ cycles apart, then grant=0 and rr_ptr=2.
- Round-robin: reqs 0, 2 and 3 each hold 1-byte frames from reset. Required: service order 0, 2, 3, and each grant is preceded by one ARB cycle with grant=0.
- Frame lock: req 0 sends a 3-byte frame while req 1 asserts req_valid throughout. Required: req_ready[1]=0 until req 0's last byte is accepted, then req 1 is granted.
- Watchdog: IDLE_TIMEOUT=16; req 2 sends 1 non-last byte, then drops req_valid. Required: release and a one-cycle timeout pulse exactly 16 uart_ready=1 cycles later, and rr_ptr=3.
- Reset mid-frame: assert rst during req 3's second byte. Required: grant=0, busy=0, uart_valid=0 on the cycle after rst is sampled; after rst deasserts, arbitration restarts from rr_ptr=0.
- Back-pressure: hold uart_ready=0 while the owner has valid data. Required: uart_valid=0, req_ready=0, and idle_cnt does not change.
